// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared occupancy states and per-stage payload widths for pipe_stage_skid
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_t;

   // EX/MEM payload: WB and MEM control, ALU result, store data, dest reg, jump info
   typedef struct packed {
      logic [1:0]  wb_ctl;
      logic [2:0]  mem_ctl;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  write_reg;
      logic        jump;
      logic [31:0] jump_target;
   } ex_mem_t;

   typedef struct packed {
      logic [1:0]  wb_ctl;
      logic [31:0] mem_data;
      logic [31:0] alu_result;
      logic [4:0]  write_reg;
   } mem_wb_t;

   typedef struct packed {
      logic [1:0]  wb_ctl;
      logic [2:0]  mem_ctl;
      logic [3:0]  ex_ctl;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } id_ex_t;

   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream valid-ready handshake bundle for one pipeline stage
interface pipe_stage_skid_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);
   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end
endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with optional 2-entry skid and stall counter
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int W    = 32,
   parameter int SKID = 1,
   parameter int CW   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   pipe_stage_skid_if.slave  bus,
   output logic [1:0]        level,
   input  logic              cnt_clr,
   output logic [CW-1:0]     stall_cnt
);
   occ_t         state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         in_fire, out_fire;

   // With the skid buffer, in_ready depends only on registered state
   assign bus.in_ready  = (SKID != 0) ? (state_q != ST_FULL)
                                      : ((state_q == ST_EMPTY) || bus.out_ready);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_data  = main_q;
   assign level         = state_q;

   assign in_fire  = bus.in_valid  && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (SKID != 0) begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_d  = bus.in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = bus.in_data;
               end else if (in_fire) begin
                  state_d = ST_FULL;
                  skid_d  = bus.in_data;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end else begin
         if (in_fire) begin
            state_d = ST_ONE;
            main_d  = bus.in_data;
         end else if (out_fire) begin
            state_d = ST_EMPTY;
         end
      end
      // Flush only drops occupancy; payload registers keep their contents
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   sat_counter #(.CW(CW)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (bus.out_valid && !bus.out_ready),
      .count (stall_cnt)
   );
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register that replaces the fixed per-stage latch-with-lock registers between CPU stages (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque W-bit payload (control + data fields packed by the instantiating stage).
- Uses a valid/ready handshake in place of a global lock, supports a synchronous flush, and optionally adds a 2-entry skid buffer so that in_ready is a registered signal.
- Exposes a saturating stall-cycle counter for performance debug.

Parameters:
- W, 32, payload width in bits (at least 1).
- SKID, 1, 1 selects the 2-entry skid buffer (registered in_ready); 0 selects a single register (combinational in_ready).
- CW, 16, stall counter width in bits (at least 2).

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  W  upstream payload.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts an entry.
- out_data  out  W  presented payload.
- level  out  2  entries held: 0, 1 or 2 (2 only when SKID=1).
- cnt_clr  in  1  clears stall_cnt.
- stall_cnt  out  CW  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
  - out_data is stable while out_valid=1 and out_ready=0.
- Reset (rst=1 at a posedge), highest priority:
  - State goes to EMPTY; out_valid=0, out_data=0, level=0, stall_cnt=0, and the skid register is cleared to 0.
  - Any in_fire in that cycle is dropped.
  - in_ready after reset: 1 for SKID=1; for SKID=0 it follows its formula, which gives 1.
- Flush (flush=1, rst=0), second priority:
  - The next state is EMPTY; held entries and any in_fire in the same cycle are discarded.
  - An out_fire in the flush cycle counts as delivered.
  - out_data and the skid register keep their old values; only the valid state clears.
  - stall_cnt is unaffected.
- SKID=1 state machine (state is the occupancy; level mirrors it):
  - in_ready = (state != FULL). This is a function of registered state only, with no combinational dependence on out_ready.
  - EMPTY: on in_fire, go to ONE with main <= in_data.
  - ONE, in_fire and out_fire: stay in ONE, main <= in_data (zero-bubble throughput).
  - ONE, in_fire and no out_fire: go to FULL, skid <= in_data.
  - ONE, out_fire only: go to EMPTY.
  - FULL: no in_fire is possible. On out_fire, go to ONE with main <= skid.
  - out_valid = (state != EMPTY); out_data = main.
- SKID=0 mode:
  - in_ready = ~out_valid | out_ready.
  - On in_fire, main <= in_data and out_valid <= 1.
  - On out_fire without in_fire, out_valid <= 0.
  - level is 0 or 1.
- Latency and ordering:
  - One cycle from in_fire to out_valid.
  - Entries leave in arrival order; none is duplicated or dropped except by rst or flush.
  - Sustained throughput is 1 entry/cycle whenever out_ready=1.
- stall_cnt:
  - Increments by 1 in each cycle with out_valid=1 and out_ready=0, while rst=0 and cnt_clr=0.
  - Holds at 2^CW-1 (saturates, no wrap).
  - cnt_clr=1 sets it to 0 next cycle; cnt_clr takes priority over increment.
  - Counted with the registered out_valid, including in a flush cycle.

Decomposition:
- Shared package pipe_pkg:
  - Occupancy state type with encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; level is driven directly from the state.
  - Payload-packing widths for each CPU stage, e.g. EX_MEM_W, assembled from the W/M control, ALU result, write data, write register number and jump fields.
- One sub-module: sat_counter (parameter CW; ports clk, rst, clr, inc, count), used for stall_cnt.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF -> after release out_valid=0, out_data=0, level=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, inject 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 on consecutive cycles starting 1 cycle after the first in_fire; level stays 1; stall_cnt=0.
- Backpressure (SKID=1): out_ready=0, inject 0xA then 0xB -> level=2, in_ready=0, 0xC is held upstream. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order, with stall_cnt equal to the number of cycles spent in the out_valid=1, out_ready=0 condition.
- Flush while FULL, with in_valid=1 on the same cycle -> next cycle out_valid=0, level=0, in_ready=1, and no entry from before the flush appears later.
- Saturation (CW=3): hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays. Then pulse cnt_clr together with an active stall condition -> stall_cnt=0 next cycle.
- SKID=0: out_ready=0 with an entry held -> in_ready=0. Then set out_ready=1 and in_valid=1 in the same cycle -> in_ready=1 combinationally and the new entry replaces the old one with no bubble.
